// File: rtl/gps_transmitter_if.sv
// gps_transmitter_if
//   Byte-stream link between the GPZDA transmitter and its sink.
//   Handshake: the master holds `valid` high with a byte on `data`; the byte
//   transfers on any clock edge where valid && ready. While valid && !ready,
//   data and valid stay stable. The sink may drive ready at any time, and
//   ready has no effect while valid is low.
//   Signals:
//     valid  master->slave  data holds a byte
//     ready  slave->master  sink accepts data this cycle
//     data   master->slave  current byte (B bits)
interface gps_transmitter_if #(
  parameter int B = 8
);
  logic         valid;
  logic         ready;
  logic [B-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/gps_transmitter.sv
// gps_transmitter
//   Serialises one sentence of the form
//   "$GPZDA,hhmmss.ss,dd,mm,yyyy,00,00*CS\r\n" onto a valid/ready byte stream.
//   The "*CS" part is left out when NoCheck=1.
//   Field strings are latched when start is accepted. Byte 0 of each string
//   is taken from its MS byte.
//   Ports:
//     clock, reset_n       system clock, async active-low reset
//     start                request a sentence (taken only while idle)
//     utc/day/month/year   ASCII field strings
//     tx (master)          valid/ready/data byte stream
//     busy                 sentence in progress
//     done                 one-cycle pulse after the LF byte transfers
//     dbg_state            current FSM state encoding
module gps_transmitter #(
  parameter int B       = 8,
  parameter int UtcLen  = 9,
  parameter bit NoCheck = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [UtcLen*B-1:0] utc,
  input  logic [2*B-1:0]      day,
  input  logic [2*B-1:0]      month,
  input  logic [4*B-1:0]      year,
  gps_transmitter_if.master   tx,
  output logic                busy,
  output logic                done,
  output logic [3:0]          dbg_state
);

  typedef enum logic [3:0] {
    S_Idle   = 4'd0,
    S_Prefix = 4'd1,
    S_UTC    = 4'd2,
    S_Day    = 4'd3,
    S_Month  = 4'd4,
    S_Year   = 4'd5,
    S_Zone   = 4'd6,
    S_Check  = 4'd7,
    S_End    = 4'd8
  } state_t;

  // The counter must reach UtcLen (the comma after the UTC field) and 6
  // (last prefix byte).
  localparam int CW = $clog2(UtcLen + 8);

  localparam logic [7*8-1:0] PREFIX = "$GPZDA,";
  localparam logic [5*8-1:0] ZONE   = "00,00";
  localparam logic [B-1:0]   COMMA  = B'(8'h2C);
  localparam logic [B-1:0]   STAR   = B'(8'h2A);
  localparam logic [B-1:0]   CR     = B'(8'h0D);
  localparam logic [B-1:0]   LF     = B'(8'h0A);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [UtcLen*B-1:0]   utc_q, utc_d;
  logic [2*B-1:0]        day_q, day_d;
  logic [2*B-1:0]        month_q, month_d;
  logic [4*B-1:0]        year_q, year_d;
  logic [B-1:0]          cks_q, cks_d;
  logic                  done_q, done_d;

  logic [B-1:0]          byte_c;
  logic                  last_c;
  logic                  in_sum_c;
  logic                  xfer_c;

  function automatic logic [B-1:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return B'(8'h30 + {4'h0, n});
    else           return B'(8'h37 + {4'h0, n});
  endfunction

  // Byte selection: current byte, whether it is the state's last one, and
  // whether it belongs to the checksummed span ('$' and '*' excluded).
  always_comb begin
    byte_c   = '0;
    last_c   = 1'b0;
    in_sum_c = 1'b0;
    case (state_q)
      S_Prefix: begin
        for (int i = 0; i < 7; i++)
          if (cnt_q == CW'(i)) byte_c = B'(PREFIX[(6-i)*8 +: 8]);
        last_c   = (cnt_q == CW'(6));
        in_sum_c = (cnt_q != '0);
      end
      S_UTC: begin
        for (int i = 0; i < UtcLen; i++)
          if (cnt_q == CW'(i)) byte_c = utc_q[(UtcLen-1-i)*B +: B];
        if (cnt_q == CW'(UtcLen)) byte_c = COMMA;
        last_c   = (cnt_q == CW'(UtcLen));
        in_sum_c = 1'b1;
      end
      S_Day: begin
        for (int i = 0; i < 2; i++)
          if (cnt_q == CW'(i)) byte_c = day_q[(1-i)*B +: B];
        if (cnt_q == CW'(2)) byte_c = COMMA;
        last_c   = (cnt_q == CW'(2));
        in_sum_c = 1'b1;
      end
      S_Month: begin
        for (int i = 0; i < 2; i++)
          if (cnt_q == CW'(i)) byte_c = month_q[(1-i)*B +: B];
        if (cnt_q == CW'(2)) byte_c = COMMA;
        last_c   = (cnt_q == CW'(2));
        in_sum_c = 1'b1;
      end
      S_Year: begin
        for (int i = 0; i < 4; i++)
          if (cnt_q == CW'(i)) byte_c = year_q[(3-i)*B +: B];
        if (cnt_q == CW'(4)) byte_c = COMMA;
        last_c   = (cnt_q == CW'(4));
        in_sum_c = 1'b1;
      end
      S_Zone: begin
        for (int i = 0; i < 5; i++)
          if (cnt_q == CW'(i)) byte_c = B'(ZONE[(4-i)*8 +: 8]);
        last_c   = (cnt_q == CW'(4));
        in_sum_c = 1'b1;
      end
      S_Check: begin
        if (cnt_q == CW'(0)) byte_c = STAR;
        if (cnt_q == CW'(1)) byte_c = hex_char(cks_q[7:4]);
        if (cnt_q == CW'(2)) byte_c = hex_char(cks_q[3:0]);
        last_c = (cnt_q == CW'(2));
      end
      S_End: begin
        if (cnt_q == CW'(0)) byte_c = CR;
        if (cnt_q == CW'(1)) byte_c = LF;
        last_c = (cnt_q == CW'(1));
      end
      default: ;
    endcase
  end

  // Next-state logic. Everything advances only on a transfer, so stalls
  // freeze the byte, the counter and the checksum together.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    utc_d   = utc_q;
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    cks_d   = cks_q;
    done_d  = 1'b0;
    xfer_c  = (state_q != S_Idle) && tx.ready;

    if (state_q == S_Idle) begin
      if (start) begin
        utc_d   = utc;
        day_d   = day;
        month_d = month;
        year_d  = year;
        cks_d   = '0;
        cnt_d   = '0;
        state_d = S_Prefix;
      end
    end else if (xfer_c) begin
      if (in_sum_c) cks_d = cks_q ^ byte_c;
      if (last_c) begin
        cnt_d = '0;
        case (state_q)
          S_Prefix: state_d = S_UTC;
          S_UTC:    state_d = S_Day;
          S_Day:    state_d = S_Month;
          S_Month:  state_d = S_Year;
          S_Year:   state_d = S_Zone;
          S_Zone:   state_d = NoCheck ? S_End : S_Check;
          S_Check:  state_d = S_End;
          S_End: begin
            state_d = S_Idle;
            done_d  = 1'b1;
          end
          default:  state_d = S_Idle;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_Idle;
      cnt_q   <= '0;
      utc_q   <= '0;
      day_q   <= '0;
      month_q <= '0;
      year_q  <= '0;
      cks_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      utc_q   <= utc_d;
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      cks_q   <= cks_d;
      done_q  <= done_d;
    end
  end

  // In idle byte_c is zero, so data reads 0 whenever valid is low.
  assign tx.valid  = (state_q != S_Idle);
  assign tx.data   = byte_c;
  assign busy      = (state_q != S_Idle);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gps_transmitter.sv
// tb_gps_transmitter
//   Directed bench for gps_transmitter. dut0 has the checksum enabled,
//   dut1 has NoCheck=1. Inputs are driven and outputs sampled on the
//   falling edge.
module tb_gps_transmitter;
  localparam int B       = 8;
  localparam int UTC_LEN = 9;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic                 start0 = 1'b0;
  logic                 start1 = 1'b0;
  logic [UTC_LEN*B-1:0] utc;
  logic [2*B-1:0]       day, month;
  logic [4*B-1:0]       year;
  logic                 busy0, done0, busy1, done1;
  logic [3:0]           st0, st1;

  gps_transmitter_if #(.B(B)) tx0 ();
  gps_transmitter_if #(.B(B)) tx1 ();

  gps_transmitter #(.B(B), .UtcLen(UTC_LEN), .NoCheck(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0),
    .utc(utc), .day(day), .month(month), .year(year),
    .tx(tx0), .busy(busy0), .done(done0), .dbg_state(st0)
  );

  gps_transmitter #(.B(B), .UtcLen(UTC_LEN), .NoCheck(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1),
    .utc(utc), .day(day), .month(month), .year(year),
    .tx(tx1), .busy(busy1), .done(done1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  logic [B-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_exp(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fields(input logic [UTC_LEN*B-1:0] u, input logic [2*B-1:0] d,
                            input logic [2*B-1:0] m, input logic [4*B-1:0] y);
    utc = u; day = d; month = m; year = y;
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clock);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
  endtask

  // Follows one sentence after start has been raised. pat 0: ready=1,
  // pat 1: ready 1,0,0 repeating. hook 1: re-pulse start and change fields
  // at byte 10. hook 2: assert reset at byte 20. chain: return in the done
  // cycle so the caller can start the next sentence immediately.
  task automatic run_stream(input int sel, input int pat, input int hook,
                            input bit chain, input int exp_len, input string tag);
    int cyc = 0, xfers = 0, dones = 0, vcyc = 0;
    bit finished = 0, last_sent = 0, stalled = 0, hook_done = 0;
    logic [B-1:0] prev = '0, d, exp_b;
    logic v, r, d_o, b_o;
    while (!finished) begin
      @(negedge clock);
      start0 = 1'b0;
      start1 = 1'b0;
      if (sel == 0) begin v = tx0.valid; d = tx0.data; d_o = done0; b_o = busy0; end
      else          begin v = tx1.valid; d = tx1.data; d_o = done1; b_o = busy1; end
      if (d_o) dones++;
      if (last_sent) begin
        check({tag, "_done_pulse"}, d_o, 1);
        check({tag, "_done_valid"}, v, 0);
        check({tag, "_done_busy"}, b_o, 0);
        finished = 1;
      end else begin
        if (cyc == 0) check({tag, "_first_valid"}, v, 1);
        if (v) vcyc++;
        if (stalled) begin
          check({tag, "_stall_valid"}, v, 1);
          check({tag, "_stall_data"}, d, prev);
        end
        r = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
        if (sel == 0) tx0.ready = r; else tx1.ready = r;
        if (hook == 1 && xfers == 10 && !hook_done) begin
          hook_done = 1;
          start0 = 1'b1;
          set_fields("000000.00", "99", "88", "7777");
        end
        if (hook == 2 && xfers == 20) begin
          reset_n = 1'b0;
          #1;
          check({tag, "_rst_valid"}, tx0.valid, 0);
          check({tag, "_rst_data"}, tx0.data, 0);
          check({tag, "_rst_busy"}, busy0, 0);
          check({tag, "_rst_done"}, done0, 0);
          check({tag, "_rst_state"}, st0, 0);
          finished = 1;
        end else if (v && r) begin
          exp_b = exp_q.pop_front();
          check({tag, "_byte"}, d, exp_b);
          xfers++;
          if (exp_q.size() == 0) last_sent = 1;
        end
        stalled = v && !r;
        prev = d;
      end
      cyc++;
      if (!finished && cyc > 400) begin
        n_cmp++;
        n_err++;
        $error("FAIL %s_timeout: observed %0d transfers expected %0d", tag, xfers, exp_len);
        finished = 1;
      end
    end
    if (sel == 0) tx0.ready = 1'b1; else tx1.ready = 1'b1;
    if (hook != 2) begin
      check({tag, "_len"}, xfers, exp_len);
      check({tag, "_done_count"}, dones, 1);
      if (pat == 0) check({tag, "_valid_cycles"}, vcyc, exp_len);
      if (!chain) begin
        @(negedge clock);
        check({tag, "_done_low"}, (sel == 0) ? done0 : done1, 0);
        check({tag, "_idle_valid"}, (sel == 0) ? tx0.valid : tx1.valid, 0);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tx0.ready = 1'b1;
    tx1.ready = 1'b1;
    set_fields("123456.78", "09", "10", "2021");

    // Reset state
    repeat (2) @(negedge clock);
    check("reset_valid", tx0.valid, 0);
    check("reset_data", tx0.data, 0);
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_state", st0, 0);
    check("reset_valid_nc", tx1.valid, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_valid", tx0.valid, 0);

    // Full-rate sentence, then a back-to-back one started in the done cycle
    load_exp("$GPZDA,123456.78,09,10,2021,00,00*67");
    pulse_start(0);
    run_stream(0, 0, 0, 1'b1, 38, "t1");
    set_fields("235959.00", "31", "12", "1999");
    start0 = 1'b1;
    load_exp("$GPZDA,235959.00,31,12,1999,00,00*6E");
    run_stream(0, 0, 0, 1'b0, 38, "b2b");

    // Stalling sink
    set_fields("123456.78", "09", "10", "2021");
    load_exp("$GPZDA,123456.78,09,10,2021,00,00*67");
    pulse_start(0);
    run_stream(0, 1, 0, 1'b0, 38, "t2");

    // No checksum variant
    load_exp("$GPZDA,123456.78,09,10,2021,00,00");
    pulse_start(1);
    run_stream(1, 0, 0, 1'b0, 35, "t3");

    // Start while busy and field changes mid-sentence are ignored
    load_exp("$GPZDA,123456.78,09,10,2021,00,00*67");
    pulse_start(0);
    run_stream(0, 0, 1, 1'b0, 38, "t4");

    // Reset mid-sentence, then a fresh sentence
    set_fields("123456.78", "09", "10", "2021");
    load_exp("$GPZDA,123456.78,09,10,2021,00,00*67");
    pulse_start(0);
    run_stream(0, 0, 2, 1'b0, 38, "t5");
    @(negedge clock);
    check("t5_hold_valid", tx0.valid, 0);
    check("t5_hold_state", st0, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("t5_post_valid", tx0.valid, 0);
    load_exp("$GPZDA,123456.78,09,10,2021,00,00*67");
    pulse_start(0);
    run_stream(0, 0, 0, 1'b0, 38, "t5r");

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
